// File: rtl/gshare_direction_predictor.sv
// rtl/gshare_direction_predictor.sv - gshare branch direction predictor
// PHT of 2-bit counters indexed by PC^GHR; speculative GHR repaired on mispredict.
module gshare_direction_predictor #(
   parameter int ADDR_WIDTH      = 32,
   parameter int PHT_INDEX_WIDTH = 8,
   parameter int HIST_LEN        = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetchValid,
   input  logic                       fetchStall,
   input  logic [ADDR_WIDTH-1:0]      fetchPc,
   input  logic                       isBranch,
   output logic                       isBranchTakenPredicted,
   output logic [PHT_INDEX_WIDTH-1:0] predIndex,
   output logic [HIST_LEN-1:0]        predGhr,
   output logic                       ready,
   input  logic                       updateValid,
   input  logic [PHT_INDEX_WIDTH-1:0] updateIndex,
   input  logic                       updateTaken,
   input  logic                       updateMispredict,
   input  logic [HIST_LEN-1:0]        updateGhr
);
   localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   generate
      if (HIST_LEN < 1 || HIST_LEN > PHT_INDEX_WIDTH) begin : g_bad_hist
         $error("HIST_LEN must lie in 1..PHT_INDEX_WIDTH");
      end
   endgenerate

   state_e                      state_q, state_d;
   logic [PHT_INDEX_WIDTH-1:0]  init_ptr_q, init_ptr_d;
   logic [HIST_LEN-1:0]         ghr_q, ghr_d;
   logic [1:0]                  pht_q [PHT_ENTRIES];

   logic                        pht_we;
   logic [PHT_INDEX_WIDTH-1:0]  pht_waddr;
   logic [1:0]                  pht_wdata;
   logic [PHT_INDEX_WIDTH-1:0]  ghr_ext;
   logic [PHT_INDEX_WIDTH-1:0]  lookup_idx;
   logic [1:0]                  upd_ctr;
   logic [HIST_LEN-1:0]         spec_ghr;
   logic [HIST_LEN-1:0]         repair_ghr;
   logic                        spec_shift;
   logic                        unused_bits;

   always_comb begin
      ghr_ext = '0;
      ghr_ext[HIST_LEN-1:0] = ghr_q;
   end

   assign lookup_idx             = fetchPc[2 +: PHT_INDEX_WIDTH] ^ ghr_ext;
   assign ready                  = (state_q == ST_RUN);
   assign isBranchTakenPredicted = ready & isBranch & fetchValid & pht_q[lookup_idx][1];
   assign predIndex              = lookup_idx;
   assign predGhr                = ghr_q;
   assign upd_ctr                = pht_q[updateIndex];
   assign spec_shift             = fetchValid & isBranch & ~fetchStall;
   assign unused_bits            = ^{fetchPc, updateGhr};

   // A one-bit history has nothing to shift in from, so it is just the newest outcome.
   generate
      if (HIST_LEN == 1) begin : g_hist1
         assign repair_ghr = updateTaken;
         assign spec_ghr   = isBranchTakenPredicted;
      end else begin : g_histn
         assign repair_ghr = {updateGhr[HIST_LEN-2:0], updateTaken};
         assign spec_ghr   = {ghr_q[HIST_LEN-2:0], isBranchTakenPredicted};
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      ghr_d      = ghr_q;
      pht_we     = 1'b0;
      pht_waddr  = init_ptr_q;
      pht_wdata  = 2'b01;
      case (state_q)
         ST_INIT: begin
            pht_we     = 1'b1;
            init_ptr_d = init_ptr_q + PHT_INDEX_WIDTH'(1);
            if (init_ptr_q == '1) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (updateValid) begin
               pht_we    = 1'b1;
               pht_waddr = updateIndex;
               if (updateTaken) begin
                  pht_wdata = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
               end else begin
                  pht_wdata = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
               end
            end
            // Repair wins over any speculative shift from the same cycle.
            if (updateValid & updateMispredict) begin
               ghr_d = repair_ghr;
            end else if (spec_shift) begin
               ghr_d = spec_ghr;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         ghr_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         ghr_q      <= ghr_d;
      end
   end

   // Storage carries no reset so it maps onto a RAM; INIT sweeps it instead.
   always_ff @(posedge clk) begin
      if (pht_we) begin
         pht_q[pht_waddr] <= pht_wdata;
      end
   end
endmodule

// File: tb/tb_gshare_direction_predictor.sv
// tb/tb_gshare_direction_predictor.sv - self-checking bench for gshare_direction_predictor
module tb_gshare_direction_predictor;
   localparam int N = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetchValid = 1'b0;
   logic        fetchStall = 1'b0;
   logic [31:0] fetchPc = '0;
   logic        isBranch = 1'b0;
   logic        isBranchTakenPredicted;
   logic [7:0]  predIndex;
   logic [7:0]  predGhr;
   logic        ready;
   logic        updateValid = 1'b0;
   logic [7:0]  updateIndex = '0;
   logic        updateTaken = 1'b0;
   logic        updateMispredict = 1'b0;
   logic [7:0]  updateGhr = '0;

   int errors = 0;
   int checks = 0;

   int model_pht [N];
   int model_ghr = 0;
   int init_cnt  = 0;
   bit model_ready = 1'b0;

   gshare_direction_predictor #(
      .ADDR_WIDTH(32), .PHT_INDEX_WIDTH(8), .HIST_LEN(8)
   ) dut (
      .clk(clk), .rst(rst),
      .fetchValid(fetchValid), .fetchStall(fetchStall), .fetchPc(fetchPc), .isBranch(isBranch),
      .isBranchTakenPredicted(isBranchTakenPredicted), .predIndex(predIndex), .predGhr(predGhr),
      .ready(ready),
      .updateValid(updateValid), .updateIndex(updateIndex), .updateTaken(updateTaken),
      .updateMispredict(updateMispredict), .updateGhr(updateGhr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: expected outputs from current inputs, then advance as the coming edge would.
   always @(negedge clk) begin
      int idx;
      int v;
      bit pred;
      idx  = ((int'(fetchPc) >> 2) & 255) ^ model_ghr;
      pred = model_ready && fetchValid && isBranch && (model_pht[idx] >= 2);
      if (!rst) begin
         check("rst_ready", ready, 0);
         check("rst_pred", isBranchTakenPredicted, 0);
         check("rst_ghr", predGhr, 0);
      end else begin
         check("cyc_ready", ready, model_ready);
         check("cyc_index", predIndex, idx);
         check("cyc_ghr", predGhr, model_ghr);
         check("cyc_pred", isBranchTakenPredicted, pred);
      end
      if (!rst) begin
         model_ready = 1'b0;
         init_cnt    = 0;
         model_ghr   = 0;
         for (int i = 0; i < N; i++) model_pht[i] = 1;
      end else if (!model_ready) begin
         init_cnt++;
         if (init_cnt == N) model_ready = 1'b1;
      end else begin
         if (updateValid) begin
            v = model_pht[updateIndex];
            model_pht[updateIndex] = updateTaken ? ((v == 3) ? 3 : v + 1) : ((v == 0) ? 0 : v - 1);
         end
         if (updateValid && updateMispredict)
            model_ghr = (int'(updateGhr) * 2 + int'(updateTaken)) % 256;
         else if (fetchValid && isBranch && !fetchStall)
            model_ghr = (model_ghr * 2 + int'(pred)) % 256;
      end
   end

   task automatic set_in(input logic fv, input logic fs, input logic br, input logic [31:0] pc,
                         input logic uv, input logic [7:0] ui, input logic ut, input logic um,
                         input logic [7:0] ug);
      fetchValid = fv; fetchStall = fs; isBranch = br; fetchPc = pc;
      updateValid = uv; updateIndex = ui; updateTaken = ut; updateMispredict = um; updateGhr = ug;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [7:0] ui, input logic ut);
      set_in(0, 0, 0, 0, 1, ui, ut, 0, 0);
      tick();
   endtask

   task automatic look(input logic [31:0] pc);
      set_in(1, 1, 1, pc, 0, 0, 0, 0, 0);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) tick();
      check("reset_ready_lit", ready, 0);

      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 400; c++) begin
         set_in(1, 0, 1, 32'(c * 4), 1, 8'(c), 1, 1, 8'hFF);
         #1;
         if (ready) break;
         n++;
         tick();
      end
      check("init_cycles", n, 256);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      for (int i = 0; i < N; i++) begin
         look(32'(i * 4));
         tick();
      end

      set_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0);
      #1;
      check("idx_0x100", predIndex, 8'h40);
      check("pred_0x40_init", isBranchTakenPredicted, 0);
      tick();
      upd(8'h40, 1);
      upd(8'h40, 1);
      look(32'h100);
      check("pred_after_2T", isBranchTakenPredicted, 1);
      tick();
      upd(8'h40, 1);
      upd(8'h40, 1);
      upd(8'h40, 0);
      look(32'h100);
      check("pred_ctr_10", isBranchTakenPredicted, 1);
      tick();

      repeat (5) upd(8'h22, 0);
      look(32'h88);
      check("pred_sat_00", isBranchTakenPredicted, 0);
      tick();
      upd(8'h22, 1);
      look(32'h88);
      check("pred_sat_01", isBranchTakenPredicted, 0);
      tick();
      upd(8'h22, 1);
      look(32'h88);
      check("pred_sat_10", isBranchTakenPredicted, 1);
      tick();

      // Each PC chosen so PC^GHR lands on the trained-taken entry 0x40.
      set_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr0", predGhr, 8'h00);
      check("spec_pred0", isBranchTakenPredicted, 1);
      tick();
      set_in(1, 0, 1, 32'h104, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr1", predGhr, 8'h01);
      check("spec_pred1", isBranchTakenPredicted, 1);
      tick();
      set_in(1, 0, 1, 32'h10C, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr3", predGhr, 8'h03);
      check("spec_pred3", isBranchTakenPredicted, 1);
      tick();
      set_in(1, 1, 1, 32'h11C, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr7", predGhr, 8'h07);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("stall_hold_ghr", predGhr, 8'h07);
      tick();

      set_in(1, 0, 1, 32'h11C, 1, 8'h05, 1, 1, 8'h5A);
      #1;
      check("repair_spec_pred", isBranchTakenPredicted, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 8'h06, 1, 1, 8'h33);
      #1;
      check("repair_ghr", predGhr, 8'hB5);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("mispredict_no_valid", predGhr, 8'hB5);
      tick();

      set_in(1, 1, 1, 32'h294, 1, 8'h10, 1, 0, 0);
      #1;
      check("same_cycle_idx", predIndex, 8'h10);
      check("same_cycle_old", isBranchTakenPredicted, 0);
      tick();
      look(32'h294);
      check("same_cycle_next", isBranchTakenPredicted, 1);
      tick();

      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("ready_drop", ready, 0);
      tick();
      tick();
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 400; c++) begin
         set_in(1, 0, 1, 32'h100, 0, 0, 0, 0, 0);
         #1;
         if (ready) break;
         n++;
         tick();
      end
      check("reinit_cycles", n, 256);
      look(32'h100);
      check("reinit_idx", predIndex, 8'h40);
      check("reinit_pred", isBranchTakenPredicted, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gshare_direction_predictor.md
Name: gshare_direction_predictor

Overview:
- Fetch-stage branch direction predictor; produces the `isBranchTakenPredicted` bit consumed directly by the branch-predict generation stage, alongside the BTB hit/target.
- Gshare scheme: the PHT of 2-bit saturating counters is indexed by fetch PC XOR a speculative global history register (GHR).
- Trained and history-repaired from the execute-stage branch resolution port.

Parameters:
- ADDR_WIDTH, 32, PC width.
- PHT_INDEX_WIDTH, 8, log2 of PHT entries (256).
- HIST_LEN, 8, GHR length in bits. Legal range 1..PHT_INDEX_WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetchValid  in  1  fetch PC valid this cycle.
- fetchStall  in  1  fetch stage stalled; no speculative state change.
- fetchPc  in  ADDR_WIDTH  PC being fetched.
- isBranch  in  1  fetched instruction is a conditional branch (predecode).
- isBranchTakenPredicted  out  1  direction prediction, combinational.
- predIndex  out  PHT_INDEX_WIDTH  PHT index used; carried down the pipe for update.
- predGhr  out  HIST_LEN  GHR value used for this prediction (pre-shift snapshot).
- ready  out  1  PHT initialisation complete.
- updateValid  in  1  branch resolved in execute.
- updateIndex  in  PHT_INDEX_WIDTH  predIndex carried with the branch.
- updateTaken  in  1  actual outcome.
- updateMispredict  in  1  direction mispredicted; triggers GHR repair.
- updateGhr  in  HIST_LEN  predGhr carried with the branch.

Behaviour:
- Index hash: `idx = fetchPc[2 +: PHT_INDEX_WIDTH] XOR {zero-extend(ghr)}`. `predIndex = idx` and `predGhr = ghr`, both combinational.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction = counter MSB.
  - `isBranchTakenPredicted = ready & isBranch & fetchValid & pht[idx][1]`.
- PHT is a single-write-port array, with no async reset on the storage, so it is RAM-inferable. Read is combinational.
- FSM, 2 states:
  - INIT (reset state):
    - Each cycle writes 01 to `pht[initPtr]` and increments `initPtr`.
    - When `initPtr` = 2^PHT_INDEX_WIDTH-1 is written, moves to RUN.
    - INIT lasts exactly 2^PHT_INDEX_WIDTH cycles after reset release.
    - `ready` = 0, all updates dropped, GHR held at 0.
  - RUN: `ready` = 1; stays until reset.
- Reset values: state = INIT, `initPtr` = 0, `ghr` = 0, `ready` = 0. With `ready` = 0, `isBranchTakenPredicted` = 0.
- Reset asserted mid-operation (INIT or RUN) returns to INIT and re-initialises the entire PHT.
- PHT training, RUN only: on `updateValid`, `pht[updateIndex]` saturating increments if `updateTaken`, else saturating decrements. 11 stays 11 on taken; 00 stays 00 on not-taken. One-cycle write.
- Lookup and update on the same index in the same cycle: lookup returns the old value (no bypass).
- GHR next-state, RUN only, priority order:
  - (1) `updateValid & updateMispredict`: `ghr <= {updateGhr[HIST_LEN-2:0], updateTaken}`. For HIST_LEN = 1, `ghr <= updateTaken`. Any same-cycle speculative shift is discarded.
  - (2) else `fetchValid & isBranch & ~fetchStall`: `ghr <= {ghr[HIST_LEN-2:0], isBranchTakenPredicted}`.
  - (3) else hold.
- `updateMispredict` without `updateValid` is ignored.
- Latency: prediction in the same cycle as `fetchPc`. Training and GHR changes are visible to the next cycle's lookup.

Test Plan:
- Reset release, PHT_INDEX_WIDTH = 8 → `ready` = 0 for exactly 256 cycles, then 1. Any branch lookup during INIT → prediction 0. `updateValid` pulses during INIT leave all counters at 01.
- After init, `fetchPc` = 0x100, GHR = 0, `isBranch` = 1 → `predIndex` = 0x40, prediction 0. Two taken updates to idx 0x40 → next lookup predicts 1. A third and fourth taken update, then one not-taken → counter 10, still predicts 1.
- Saturation: five not-taken updates on one index → counter 00. One taken update → 01, predicts 0.
- Speculative GHR: three consecutive predicted-taken branches from GHR = 0 → `predGhr` sequence 0x00, 0x01, 0x03. `fetchStall` = 1 on the 4th branch → GHR stays 0x07.
- Repair: in the same cycle, a speculative branch fetch plus `updateValid` = 1, `updateMispredict` = 1, `updateGhr` = 0x5A, `updateTaken` = 1 → GHR = 0xB5 next cycle (speculative shift discarded).
- Same-cycle lookup and update to idx 0x10 (counter 01, taken) → lookup predicts 0; the following cycle predicts 1. Assert `rst` in RUN → `ready` drops immediately and the 256-cycle re-init restarts.
